// File: rtl/seg_scan_display.sv
// seg_scan_display: snapshots one of CHANNELS debug words and scans a DIGITS-wide hex page
// onto a common-anode display; on-chip debounced keys step the page and toggle freeze.
module seg_scan_display #(
  parameter int DIGITS = 2,
  parameter int CHANNELS = 4,
  parameter int DIV = 50000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [32*CHANNELS-1:0]   data,
  input  logic [3:0]               sw,
  input  logic [1:0]               key,
  output logic [DIGITS-1:0]        com,
  output logic [7:0]               segs,
  output logic [3:0]               leds
);
  localparam int PAGES = 32 / (4 * DIGITS);
  localparam int PW = PAGES > 1 ? $clog2(PAGES) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(CHANNELS);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DEBOUNCE);
  localparam logic [127:0] FONT = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                   8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, pulse_q, pulse_d;
  logic [1:0][BW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]        page_q, page_d;
  logic                 frozen_q, frozen_d;
  logic [31:0]          snap_q, snap_d;
  logic [CW-1:0]        div_q, div_d;
  logic [DW-1:0]        digit_q, digit_d;
  logic [DIGITS-1:0]    com_q, com_d;
  logic [7:0]           segs_q, segs_d, glyph;
  logic [3:0]           leds_q, leds_d, sel, nib;
  logic                 div_wrap;
  always_comb begin
    sync1_d = key;
    sync2_d = sync1_q;
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    // a level is accepted only after DEBOUNCE consecutive samples that disagree with it
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (sync2_q[i] == lvl_q[i] || cnt_q[i] == BW'(DEBOUNCE - 1)) ? '0 : cnt_q[i] + 1'b1;
      lvl_d[i] = (sync2_q[i] != lvl_q[i] && cnt_q[i] == BW'(DEBOUNCE - 1)) ? sync2_q[i] : lvl_q[i];
    end
    pulse_d = lvl_q & ~lvl_d;
    page_d = PAGES == 1 ? '0 :
             pulse_q[0] ? (page_q == PW'(PAGES - 1) ? '0 : page_q + 1'b1) : page_q;
    frozen_d = frozen_q ^ pulse_q[1];
    sel = sw & 4'((1 << SW) - 1);
    snap_d = frozen_q ? snap_q : (int'(sel) < CHANNELS ? data[32*sel +: 32] : '0);
    div_wrap = div_q == CW'(DIV - 1);
    div_d = div_wrap ? '0 : div_q + 1'b1;
    digit_d = div_wrap ? (digit_q == DW'(DIGITS - 1) ? '0 : digit_q + 1'b1) : digit_q;
    // com and segs both derive from the current digit so they switch on the same edge
    nib = 4'(snap_q >> (4 * (int'(page_q) * DIGITS + int'(digit_q))));
    glyph = FONT[8*nib +: 8];
    segs_d = {glyph[7] & ~(frozen_q && digit_q == '0), glyph[6:0]};
    com_d = ~(DIGITS'(1) << digit_q);
    leds_d = {~&lvl_q, frozen_q, 2'(page_q)};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      lvl_q    <= 2'b11;
      cnt_q    <= '0;
      pulse_q  <= '0;
      page_q   <= '0;
      frozen_q <= 1'b0;
      snap_q   <= '0;
      div_q    <= '0;
      digit_q  <= '0;
      com_q    <= '1;
      segs_q   <= 8'hFF;
      leds_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      page_q   <= page_d;
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
      div_q    <= div_d;
      digit_q  <= digit_d;
      com_q    <= com_d;
      segs_q   <= segs_d;
      leds_q   <= leds_d;
    end
  end
  assign com = com_q;
  assign segs = segs_q;
  assign leds = leds_q;
endmodule
